// File: rtl/swerv_axi_mem_slave.sv
// AXI4 slave terminating one SweRV master port with an on-chip 64-bit RAM.
// Serves one transaction at a time; INCR/FIXED bursts, narrow sizes, byte strobes.
module swerv_axi_mem_slave #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 16,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            axi_awvalid,
    output logic            axi_awready,
    input  logic [ID_W-1:0] axi_awid,
    input  logic [31:0]     axi_awaddr,
    input  logic [7:0]      axi_awlen,
    input  logic [2:0]      axi_awsize,
    input  logic [1:0]      axi_awburst,

    input  logic            axi_wvalid,
    output logic            axi_wready,
    input  logic [63:0]     axi_wdata,
    input  logic [7:0]      axi_wstrb,
    input  logic            axi_wlast,

    output logic            axi_bvalid,
    input  logic            axi_bready,
    output logic [1:0]      axi_bresp,
    output logic [ID_W-1:0] axi_bid,

    input  logic            axi_arvalid,
    output logic            axi_arready,
    input  logic [ID_W-1:0] axi_arid,
    input  logic [31:0]     axi_araddr,
    input  logic [7:0]      axi_arlen,
    input  logic [2:0]      axi_arsize,
    input  logic [1:0]      axi_arburst,

    output logic            axi_rvalid,
    input  logic            axi_rready,
    output logic [ID_W-1:0] axi_rid,
    output logic [63:0]     axi_rdata,
    output logic [1:0]      axi_rresp,
    output logic            axi_rlast
);

    localparam int unsigned IDX_W = ADDR_W - 3;
    localparam int unsigned DEPTH = 1 << IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t          state;
    logic            prio_w;
    logic [ID_W-1:0] id_q;
    logic [31:0]     addr_q;
    logic [7:0]      len_q;
    logic [7:0]      beat_cnt;
    logic [2:0]      size_q;
    logic [1:0]      burst_q;
    logic [1:0]      err_q;

    logic [63:0]     mem [DEPTH];

    logic            aw_grant_c;
    logic            ar_grant_c;
    logic            w_hs_c;
    logic            wr_en_c;
    logic [31:0]     acc_addr_c;
    logic [7:0]      acc_len_c;
    logic [2:0]      acc_size_c;
    logic [1:0]      acc_burst_c;
    logic [1:0]      acc_err_c;
    logic [31:0]     next_addr_c;
    logic [7:0]      beat_inc_c;
    logic            w_last_c;
    logic [1:0]      w_err_c;

    // Arbitration, address decode/check, and next beat address
    always_comb begin
        aw_grant_c  = axi_awvalid & (~axi_arvalid | prio_w);
        ar_grant_c  = axi_arvalid & (~axi_awvalid | ~prio_w);
        axi_awready = (state == IDLE) & aw_grant_c;
        axi_arready = (state == IDLE) & ar_grant_c;
        axi_wready  = (state == WR_DATA);
        w_hs_c      = (state == WR_DATA) & axi_wvalid;
        wr_en_c     = w_hs_c & (err_q == RESP_OKAY) & ~rst;

        acc_addr_c  = aw_grant_c ? axi_awaddr  : axi_araddr;
        acc_len_c   = aw_grant_c ? axi_awlen   : axi_arlen;
        acc_size_c  = aw_grant_c ? axi_awsize  : axi_arsize;
        acc_burst_c = aw_grant_c ? axi_awburst : axi_arburst;

        acc_err_c = RESP_OKAY;
        if (acc_addr_c[31:ADDR_W] != BASE[31:ADDR_W]) begin
            acc_err_c = RESP_DECERR;
        end else if ((acc_size_c > 3'd3) || (acc_burst_c == BURST_WRAP) ||
                     (acc_burst_c == BURST_RSVD)) begin
            acc_err_c = RESP_SLVERR;
        end

        next_addr_c = (burst_q == BURST_FIXED) ? addr_q : addr_q + (32'd1 << size_q);
        beat_inc_c  = beat_cnt + 8'd1;
        w_last_c    = (beat_cnt == len_q);
        w_err_c     = ((err_q == RESP_OKAY) && (axi_wlast != w_last_c)) ? RESP_SLVERR : err_q;
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int i = 0; i < 8; i++) begin
                if (axi_wstrb[i]) begin
                    mem[addr_q[ADDR_W-1:3]][8*i +: 8] <= axi_wdata[8*i +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered B and R channel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio_w     <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt   <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_q      <= RESP_OKAY;
            axi_bvalid <= 1'b0;
            axi_bresp  <= '0;
            axi_bid    <= '0;
            axi_rvalid <= 1'b0;
            axi_rid    <= '0;
            axi_rdata  <= '0;
            axi_rresp  <= '0;
            axi_rlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_grant_c || ar_grant_c) begin
                        id_q     <= aw_grant_c ? axi_awid : axi_arid;
                        addr_q   <= acc_addr_c;
                        len_q    <= acc_len_c;
                        size_q   <= acc_size_c;
                        burst_q  <= acc_burst_c;
                        beat_cnt <= '0;
                        err_q    <= acc_err_c;
                        prio_w   <= ~prio_w;
                        if (aw_grant_c) begin
                            state <= WR_DATA;
                        end else begin
                            state      <= RD_DATA;
                            axi_rvalid <= 1'b1;
                            axi_rid    <= axi_arid;
                            axi_rresp  <= acc_err_c;
                            axi_rlast  <= (axi_arlen == 8'd0);
                            axi_rdata  <= (acc_err_c == RESP_OKAY) ?
                                          mem[acc_addr_c[ADDR_W-1:3]] : 64'd0;
                        end
                    end
                end
                WR_DATA: begin
                    if (axi_wvalid) begin
                        addr_q   <= next_addr_c;
                        beat_cnt <= beat_inc_c;
                        err_q    <= w_err_c;
                        if (w_last_c) begin
                            state      <= WR_RESP;
                            axi_bvalid <= 1'b1;
                            axi_bid    <= id_q;
                            axi_bresp  <= w_err_c;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi_bready) begin
                        axi_bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (axi_rready) begin
                        if (axi_rlast) begin
                            axi_rvalid <= 1'b0;
                            axi_rlast  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            addr_q    <= next_addr_c;
                            beat_cnt  <= beat_inc_c;
                            axi_rlast <= (beat_inc_c == len_q);
                            axi_rdata <= (err_q == RESP_OKAY) ?
                                         mem[next_addr_c[ADDR_W-1:3]] : 64'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_swerv_axi_mem_slave.sv
// Directed bench for swerv_axi_mem_slave: vector table plus burst/arbitration/reset sequences.
module tb_swerv_axi_mem_slave;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned NV     = 13;

    logic            clk = 1'b0;
    logic            rst;
    logic            axi_awvalid, axi_awready;
    logic [ID_W-1:0] axi_awid;
    logic [31:0]     axi_awaddr;
    logic [7:0]      axi_awlen;
    logic [2:0]      axi_awsize;
    logic [1:0]      axi_awburst;
    logic            axi_wvalid, axi_wready;
    logic [63:0]     axi_wdata;
    logic [7:0]      axi_wstrb;
    logic            axi_wlast;
    logic            axi_bvalid, axi_bready;
    logic [1:0]      axi_bresp;
    logic [ID_W-1:0] axi_bid;
    logic            axi_arvalid, axi_arready;
    logic [ID_W-1:0] axi_arid;
    logic [31:0]     axi_araddr;
    logic [7:0]      axi_arlen;
    logic [2:0]      axi_arsize;
    logic [1:0]      axi_arburst;
    logic            axi_rvalid, axi_rready;
    logic [ID_W-1:0] axi_rid;
    logic [63:0]     axi_rdata;
    logic [1:0]      axi_rresp;
    logic            axi_rlast;

    swerv_axi_mem_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .BASE(32'h0)) dut (
        .clk(clk), .rst(rst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
        .axi_bid(axi_bid),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [1:0]  exp_resp;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t        vec [NV];
    int          tests = 0;
    int          fails = 0;
    int          overlap = 0;
    logic [63:0] wbeats [16];
    logic [63:0] rbeats [16];
    logic [1:0]  rresps [16];
    logic        rlasts [16];
    logic [3:0]  rids   [16];
    int          rcyc   [16];
    logic [1:0]  bresp_s;
    logic [3:0]  bid_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address channels must never be ready while a data/response phase is active
    always @(negedge clk) begin
        if (!rst) begin
            if (axi_bvalid && axi_rvalid) overlap++;
            if ((axi_awready || axi_arready) && (axi_bvalid || axi_rvalid || axi_wready)) overlap++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi_awvalid = 1'b1; axi_awid = id; axi_awaddr = addr;
        axi_awlen = len; axi_awsize = size; axi_awburst = burst;
        #1;
        while (!axi_awready && n < 50) begin @(negedge clk); #1; n++; end
        check("awready", 64'(axi_awready), 64'd1);
        @(posedge clk); @(negedge clk);
        axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        axi_arvalid = 1'b1; axi_arid = id; axi_araddr = addr;
        axi_arlen = len; axi_arsize = size; axi_arburst = burst;
        #1;
        while (!axi_arready && n < 50) begin @(negedge clk); #1; n++; end
        check("arready", 64'(axi_arready), 64'd1);
        @(posedge clk); @(negedge clk);
        axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] len, input logic [7:0] strb, input logic bad_wlast);
        for (int k = 0; k <= int'(len); k++) begin
            int n = 0;
            axi_wvalid = 1'b1; axi_wdata = wbeats[k]; axi_wstrb = strb;
            axi_wlast  = (k == int'(len)) ^ (bad_wlast && k == 0);
            #1;
            while (!axi_wready && n < 50) begin @(negedge clk); #1; n++; end
            check("wready", 64'(axi_wready), 64'd1);
            @(posedge clk); @(negedge clk);
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [3:0] id);
        int n = 0;
        while (!axi_bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_latency", 64'(n), 64'd0);
        resp = axi_bresp; id = axi_bid;
        @(negedge clk);
        check("b_hold_valid", 64'(axi_bvalid), 64'd1);
        check("b_hold_resp", 64'(axi_bresp), 64'(resp));
        axi_bready = 1'b1;
        @(posedge clk); @(negedge clk);
        axi_bready = 1'b0;
        check("b_drop", 64'(axi_bvalid), 64'd0);
    endtask

    task automatic collect_r(input logic [7:0] len, input logic [31:0] pat);
        int          k = 0;
        int          cyc = 0;
        logic        hold_v = 1'b0;
        logic [63:0] hd = '0;
        logic        hl = 1'b0;
        logic [1:0]  hr = '0;
        while (k <= int'(len) && cyc < 200) begin
            axi_rready = pat[cyc[4:0]];
            if (hold_v) begin
                check("r_stable_valid", 64'(axi_rvalid), 64'd1);
                check("r_stable_data", axi_rdata, hd);
                check("r_stable_last", 64'(axi_rlast), 64'(hl));
                check("r_stable_resp", 64'(axi_rresp), 64'(hr));
                hold_v = 1'b0;
            end
            if (axi_rvalid) begin
                if (axi_rready) begin
                    rbeats[k] = axi_rdata; rresps[k] = axi_rresp;
                    rlasts[k] = axi_rlast; rids[k] = axi_rid; rcyc[k] = cyc;
                    k++;
                end else begin
                    hold_v = 1'b1; hd = axi_rdata; hl = axi_rlast; hr = axi_rresp;
                end
            end
            @(negedge clk);
            cyc++;
        end
        axi_rready = 1'b0;
        check("r_beats", 64'(k), 64'(len) + 64'd1);
        check("rvalid_drop", 64'(axi_rvalid), 64'd0);
    endtask

    initial begin
        vec[0]  = '{1'b1, 4'h3, 32'h0000_0008, 3'd3, 2'b01, 64'hDEADBEEF_01234567, 8'hFF, 2'b00, 64'h0};
        vec[1]  = '{1'b0, 4'h5, 32'h0000_0008, 3'd3, 2'b01, 64'h0, 8'h00, 2'b00, 64'hDEADBEEF_01234567};
        vec[2]  = '{1'b1, 4'h1, 32'h0000_0200, 3'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 64'h0};
        vec[3]  = '{1'b1, 4'h2, 32'h0000_0202, 3'd0, 2'b01, 64'h0000_0000_005A_0000, 8'h04, 2'b00, 64'h0};
        vec[4]  = '{1'b0, 4'h2, 32'h0000_0200, 3'd3, 2'b01, 64'h0, 8'h00, 2'b00, 64'hFFFF_FFFF_FF5A_FFFF};
        vec[5]  = '{1'b1, 4'h6, 32'h0000_0008, 3'd3, 2'b10, 64'h1234, 8'hFF, 2'b10, 64'h0};
        vec[6]  = '{1'b1, 4'h7, 32'h0000_0008, 3'd4, 2'b01, 64'h5678, 8'hFF, 2'b10, 64'h0};
        vec[7]  = '{1'b1, 4'h8, 32'h0000_0008, 3'd3, 2'b11, 64'h9ABC, 8'hFF, 2'b10, 64'h0};
        vec[8]  = '{1'b0, 4'h9, 32'h0000_0008, 3'd3, 2'b10, 64'h0, 8'h00, 2'b10, 64'h0};
        vec[9]  = '{1'b0, 4'hA, 32'h0000_0008, 3'd3, 2'b00, 64'h0, 8'h00, 2'b00, 64'hDEADBEEF_01234567};
        vec[10] = '{1'b1, 4'hB, 32'h0001_0008, 3'd3, 2'b01, 64'h77, 8'hFF, 2'b11, 64'h0};
        vec[11] = '{1'b0, 4'hC, 32'h0000_0008, 3'd3, 2'b01, 64'h0, 8'h00, 2'b00, 64'hDEADBEEF_01234567};
        vec[12] = '{1'b0, 4'hD, 32'h0000_0008, 3'd5, 2'b01, 64'h0, 8'h00, 2'b10, 64'h0};

        rst = 1'b1;
        axi_awvalid = 0; axi_awid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 0; axi_awburst = 0;
        axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0; axi_bready = 0;
        axi_arvalid = 0; axi_arid = 0; axi_araddr = 0; axi_arlen = 0; axi_arsize = 0; axi_arburst = 0;
        axi_rready = 0;
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(axi_awready), 64'd0);
        check("rst_arready", 64'(axi_arready), 64'd0);
        check("rst_wready", 64'(axi_wready), 64'd0);
        check("rst_bvalid", 64'(axi_bvalid), 64'd0);
        check("rst_bresp_bid", 64'({axi_bresp, axi_bid}), 64'd0);
        check("rst_rvalid", 64'(axi_rvalid), 64'd0);
        check("rst_r_fields", 64'({axi_rid, axi_rresp, axi_rlast}), 64'd0);
        check("rst_rdata", axi_rdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset alternate W, R, W
        axi_awvalid = 1; axi_awid = 4'h1; axi_awaddr = 32'h500; axi_awlen = 0; axi_awsize = 3; axi_awburst = 2'b01;
        axi_arvalid = 1; axi_arid = 4'h2; axi_araddr = 32'h500; axi_arlen = 0; axi_arsize = 3; axi_arburst = 2'b01;
        #1;
        check("arb1_awready", 64'(axi_awready), 64'd1);
        check("arb1_arready", 64'(axi_arready), 64'd0);
        @(posedge clk); @(negedge clk);
        axi_awvalid = 0;
        wbeats[0] = 64'h11;
        send_w(8'd0, 8'hFF, 1'b0);
        wait_b(bresp_s, bid_s);
        check("arb1_bresp", 64'(bresp_s), 64'd0);
        axi_awvalid = 1; axi_awid = 4'h3; axi_awaddr = 32'h508;
        #1;
        check("arb2_awready", 64'(axi_awready), 64'd0);
        check("arb2_arready", 64'(axi_arready), 64'd1);
        @(posedge clk); @(negedge clk);
        axi_arvalid = 0;
        collect_r(8'd0, 32'hFFFF_FFFF);
        check("arb2_rdata", rbeats[0], 64'h11);
        check("arb2_rid", 64'(rids[0]), 64'h2);
        axi_arvalid = 1;
        #1;
        check("arb3_awready", 64'(axi_awready), 64'd1);
        check("arb3_arready", 64'(axi_arready), 64'd0);
        @(posedge clk); @(negedge clk);
        axi_awvalid = 0;
        wbeats[0] = 64'h22;
        send_w(8'd0, 8'hFF, 1'b0);
        wait_b(bresp_s, bid_s);
        axi_arvalid = 0;
        check("arb3_bid", 64'(bid_s), 64'h3);

        // Single-beat vector table
        for (int i = 0; i < int'(NV); i++) begin
            if (vec[i].is_wr) begin
                send_aw(vec[i].id, vec[i].addr, 8'd0, vec[i].size, vec[i].burst);
                wbeats[0] = vec[i].wdata;
                send_w(8'd0, vec[i].wstrb, 1'b0);
                wait_b(bresp_s, bid_s);
                check($sformatf("v%0d_bresp", i), 64'(bresp_s), 64'(vec[i].exp_resp));
                check($sformatf("v%0d_bid", i), 64'(bid_s), 64'(vec[i].id));
            end else begin
                send_ar(vec[i].id, vec[i].addr, 8'd0, vec[i].size, vec[i].burst);
                collect_r(8'd0, 32'hFFFF_FFFF);
                check($sformatf("v%0d_rdata", i), rbeats[0], vec[i].exp_rdata);
                check($sformatf("v%0d_rresp", i), 64'(rresps[0]), 64'(vec[i].exp_resp));
                check($sformatf("v%0d_rid", i), 64'(rids[0]), 64'(vec[i].id));
                check($sformatf("v%0d_rlast", i), 64'(rlasts[0]), 64'd1);
            end
        end

        // 4-beat INCR write/read, full throughput
        for (int k = 0; k < 4; k++) wbeats[k] = 64'(k + 1);
        send_aw(4'h4, 32'h100, 8'd3, 3'd3, 2'b01);
        send_w(8'd3, 8'hFF, 1'b0);
        wait_b(bresp_s, bid_s);
        check("incr_bresp", 64'(bresp_s), 64'd0);
        send_ar(4'h5, 32'h100, 8'd3, 3'd3, 2'b01);
        collect_r(8'd3, 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("incr_rdata%0d", k), rbeats[k], 64'(k + 1));
            check($sformatf("incr_rlast%0d", k), 64'(rlasts[k]), 64'(k == 3));
            check($sformatf("incr_cycle%0d", k), 64'(rcyc[k]), 64'(k));
        end

        // FIXED burst keeps hitting the same word
        wbeats[0] = 64'hA; wbeats[1] = 64'hB;
        send_aw(4'h6, 32'h300, 8'd1, 3'd3, 2'b00);
        send_w(8'd1, 8'hFF, 1'b0);
        wait_b(bresp_s, bid_s);
        check("fixed_bresp", 64'(bresp_s), 64'd0);
        send_ar(4'h6, 32'h300, 8'd1, 3'd3, 2'b00);
        collect_r(8'd1, 32'hFFFF_FFFF);
        check("fixed_rdata0", rbeats[0], 64'hB);
        check("fixed_rdata1", rbeats[1], 64'hB);

        // Out-of-range 2-beat write/read: DECERR, no RAM update
        wbeats[0] = 64'hAAAA; wbeats[1] = 64'hBBBB;
        send_aw(4'h7, 32'h0001_0000, 8'd1, 3'd3, 2'b01);
        send_w(8'd1, 8'hFF, 1'b0);
        wait_b(bresp_s, bid_s);
        check("oor_bresp", 64'(bresp_s), 64'h3);
        check("oor_bid", 64'(bid_s), 64'h7);
        send_ar(4'h8, 32'h0001_0000, 8'd1, 3'd3, 2'b01);
        collect_r(8'd1, 32'hFFFF_FFFF);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("oor_rresp%0d", k), 64'(rresps[k]), 64'h3);
            check($sformatf("oor_rdata%0d", k), rbeats[k], 64'h0);
            check($sformatf("oor_rlast%0d", k), 64'(rlasts[k]), 64'(k == 1));
        end
        send_ar(4'h8, 32'h8, 8'd0, 3'd3, 2'b01);
        collect_r(8'd0, 32'hFFFF_FFFF);
        check("oor_ram_kept", rbeats[0], 64'hDEADBEEF_01234567);

        // Early wlast turns an OKAY write into SLVERR
        wbeats[0] = 64'h1; wbeats[1] = 64'h2;
        send_aw(4'h9, 32'h400, 8'd1, 3'd3, 2'b01);
        send_w(8'd1, 8'hFF, 1'b1);
        wait_b(bresp_s, bid_s);
        check("wlast_bresp", 64'(bresp_s), 64'h2);

        // Backpressure on a 4-beat read
        send_ar(4'hA, 32'h100, 8'd3, 3'd3, 2'b01);
        collect_r(8'd3, 32'hAAAA_AAAA);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_rdata%0d", k), rbeats[k], 64'(k + 1));
            check($sformatf("bp_rlast%0d", k), 64'(rlasts[k]), 64'(k == 3));
        end

        // Reset during beat 2 of a read, then a normal read
        send_ar(4'hB, 32'h100, 8'd3, 3'd3, 2'b01);
        axi_rready = 1'b1;
        check("rst_beat1", axi_rdata, 64'd1);
        @(negedge clk);
        check("rst_beat2", axi_rdata, 64'd2);
        rst = 1'b1; axi_rready = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", 64'(axi_rvalid), 64'd0);
        check("midrst_rdata", axi_rdata, 64'd0);
        check("midrst_rfields", 64'({axi_rid, axi_rresp, axi_rlast}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        send_ar(4'hC, 32'h100, 8'd3, 3'd3, 2'b01);
        collect_r(8'd3, 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("postrst_rdata%0d", k), rbeats[k], 64'(k + 1));
            check($sformatf("postrst_rid%0d", k), 64'(rids[k]), 64'hC);
        end

        check("no_overlap", 64'(overlap), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/swerv_axi_mem_slave.md
Name: swerv_axi_mem_slave

Overview:
- AXI4 responder that terminates one SweRV master port (LSU, IFU or SB) with an on-chip 64-bit RAM. It is the slave end of the core's master AXI interface.
- Used in the SoC as the boot/data RAM target behind an interconnect, and standalone in core-level simulation.
- Serves one transaction at a time. Supports INCR and FIXED bursts, narrow sizes and byte strobes.

Parameters:
- ID_W, 4, width of awid/arid/bid/rid. Set to RV_LSU_BUS_TAG, RV_IFU_BUS_TAG or RV_SB_BUS_TAG at instantiation.
- ADDR_W, 16, decoded byte-address bits. RAM depth is 2^(ADDR_W-3) 64-bit words.
- BASE, 32'h0, base address of the RAM. Must be aligned to 2^ADDR_W.

Ports:
- clk  in  1  core clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- axi_awvalid in 1; axi_awready out 1; axi_awid in ID_W; axi_awaddr in 32; axi_awlen in 8; axi_awsize in 3; axi_awburst in 2.
- axi_wvalid in 1; axi_wready out 1; axi_wdata in 64; axi_wstrb in 8; axi_wlast in 1.
- axi_bvalid out 1; axi_bready in 1; axi_bresp out 2; axi_bid out ID_W.
- axi_arvalid in 1; axi_arready out 1; axi_arid in ID_W; axi_araddr in 32; axi_arlen in 8; axi_arsize in 3; axi_arburst in 2.
- axi_rvalid out 1; axi_rready in 1; axi_rid out ID_W; axi_rdata out 64; axi_rresp out 2; axi_rlast out 1.

Behaviour:
- Reset and clocking: one clock; synchronous active-high reset `rst`. On reset, state goes to IDLE and every output is 0: ready signals, valid signals, resp, id, rdata, rlast. The write-priority flag resets to "write first". RAM contents are not reset.
- States: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE arbitration:
  - awready = (state==IDLE) & awvalid_granted; arready = (state==IDLE) & arvalid_granted.
  - If only one of awvalid/arvalid is high, that one is granted.
  - If both are high, the priority flag picks the winner. The flag toggles after every accepted address, so simultaneous requests alternate W, R, W, R.
- Address accept: latch id, addr, len, size and burst, and clear beat_cnt and err.
- Error checks at accept:
  - If addr[31:ADDR_W] != BASE[31:ADDR_W], set err=DECERR (2'b11).
  - Else if size>3 or burst==WRAP or burst==2'b11, set err=SLVERR (2'b10).
- Beat address:
  - INCR: addr += (1<<size) after each beat, in 32-bit arithmetic with no 4 KB check. Wrap inside the RAM uses the index addr[ADDR_W-1:3].
  - FIXED: addr is constant.
- WR_DATA:
  - wready=1.
  - On each W handshake with err==OKAY, write RAM bytes i where wstrb[i]=1. With err!=OKAY, no RAM update.
  - beat_cnt counts up. When beat_cnt==len at handshake, go to WR_RESP.
  - If wlast does not equal (beat_cnt==len) on any beat and err was OKAY, set SLVERR.
- WR_RESP:
  - bvalid=1 registered the cycle after the last W beat, with bid=latched id and bresp=err.
  - Hold all B outputs stable until bready. Then go to IDLE with bvalid=0 on the next cycle.
- RD_DATA:
  - rvalid=1 the cycle after AR acceptance, with rdata = RAM[beat index], registered.
  - rid=id, rresp=err, rlast=(beat_cnt==len).
  - If err!=OKAY, rdata=0.
  - On an R handshake that is not the last beat, load the next beat at the same edge. Throughput is 1 beat per cycle with rready held high.
  - rready=0 holds rdata/rlast/rresp stable.
  - After the last handshake, go to IDLE with rvalid=0.
- Concurrency: no read/write overlap. Each transaction completes before IDLE accepts the next address, so minimum turnaround is 1 IDLE cycle. A write and a read to the same address in order therefore read back the new data.
- Reset mid-transaction: the transaction is abandoned. Outputs are 0 the cycle after rst, and RAM writes already performed are kept.

Test Plan:
- Single write then read: AW addr=BASE+0x8, len 0, size 3, wdata=64'hDEADBEEF_01234567, strb FF; then AR same address. Required: bresp 0, rdata=64'hDEADBEEF_01234567, rlast=1, ids echoed.
- 4-beat INCR burst write then read at BASE+0x100, size 3, data 1..4, rready high. Required: 4 consecutive rvalid cycles with data 1,2,3,4; rlast only on the 4th.
- Narrow/strobe: write 64'hFF..FF, then size 0 byte writes with strb 8'h04, wdata[23:16]=8'h5A. Required: read-back 64'hFFFF_FFFF_FF5A_FFFF.
- Simultaneous awvalid and arvalid held in IDLE three times after reset. Required: grants W, R, W, and no B or R overlap.
- Out-of-range address BASE+2^ADDR_W, len 1, write then read. Required: bresp=2'b11, rresp=2'b11 on both beats, rdata=0, RAM unchanged.
- Backpressure and reset: rready toggled 0/1 in a 4-beat read must keep data stable while low. Asserting rst during beat 2 must give rvalid=0 the next cycle, and a subsequent read must work normally.
